// File: rtl/io_dev_pkg.sv
// Shared constants for the IO responder: bus qualifiers, register map,
// timer control bit positions and UART transmitter states.
package io_dev_pkg;

   localparam logic        RAM_ENABLE = 1'b1;
   localparam logic        RAM_WRITE  = 1'b1;
   localparam logic [31:0] ZERO       = 32'h0000_0000;

   // Register indices are ioAddr[7:2].
   localparam logic [5:0] REG_LED   = 6'h00;
   localparam logic [5:0] REG_SW    = 6'h01;
   localparam logic [5:0] REG_TCNT  = 6'h02;
   localparam logic [5:0] REG_TCMP  = 6'h03;
   localparam logic [5:0] REG_TCTRL = 6'h04;
   localparam logic [5:0] REG_UART  = 6'h05;

   localparam int TCTRL_EN   = 0;
   localparam int TCTRL_AR   = 1;
   localparam int TCTRL_IE   = 2;
   localparam int TCTRL_FLAG = 8;

   localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } tctrl_t;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   function automatic logic [5:0] reg_idx(input logic [31:0] addr);
      return addr[7:2];
   endfunction

endpackage

// File: rtl/io_dev_uart_tx.sv
// 8N1 serial transmitter: one start bit, eight data bits LSB first, one stop bit.
//
// state | meaning
// IDLE  | line high, waiting for start
// START | start bit (low) for CLK_DIV cycles
// DATA  | shift[0] on the line, 8 bits of CLK_DIV cycles each
// STOP  | stop bit (high) for CLK_DIV cycles, then back to IDLE
module uart_tx
   import io_dev_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int               CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   uart_state_t      state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       bit_cnt, bit_nx;
   logic [7:0]       shift, shift_nx;
   logic             tx_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= UART_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_cnt <= bit_nx;
         shift   <= shift_nx;
         tx      <= tx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      bit_nx   = bit_cnt;
      shift_nx = shift;
      case (state)
         UART_IDLE: begin
            if (start) begin
               state_nx = UART_START;
               shift_nx = data;
               bit_nx   = '0;
               cnt_nx   = '0;
            end
         end
         UART_START: begin
            if (cnt == CNT_LAST) begin
               cnt_nx   = '0;
               state_nx = UART_DATA;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         UART_DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nx = '0;
               if (bit_cnt == 3'd7) begin
                  state_nx = UART_STOP;
               end else begin
                  bit_nx   = bit_cnt + 3'd1;
                  shift_nx = {1'b0, shift[7:1]};
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         UART_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nx   = '0;
               state_nx = UART_IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = UART_IDLE;
      endcase
   end

   // The line level is registered from the next state so uartTx never glitches.
   always_comb begin
      tx_nx = 1'b1;
      case (state_nx)
         UART_START: tx_nx = 1'b0;
         UART_DATA:  tx_nx = shift_nx[0];
         default:    tx_nx = 1'b1;
      endcase
   end

   assign busy = (state != UART_IDLE);

endmodule

// File: rtl/io_dev.sv
// Memory-mapped IO responder: LED register, synchronized switches,
// 32-bit timer with compare interrupt and an 8N1 UART transmitter.
module io_dev
   import io_dev_pkg::*;
#(
   parameter int CLK_DIV = 434,
   parameter int LED_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ioCe,
   input  logic             ioWe,
   input  logic [31:0]      ioAddr,
   input  logic [31:0]      ioWtData,
   output logic [31:0]      ioRdData,
   input  logic [LED_W-1:0] sw,
   output logic [LED_W-1:0] led,
   output logic             uartTx,
   output logic             irq
);

   logic       access, wr;
   logic [5:0] idx;
   logic       unused_addr;

   assign access      = (ioCe == RAM_ENABLE);
   assign wr          = access && (ioWe == RAM_WRITE);
   assign idx         = reg_idx(ioAddr);
   assign unused_addr = ^{ioAddr[31:8], ioAddr[1:0]};

   logic wr_led, wr_tcnt, wr_tcmp, wr_tctrl, wr_uart;
   assign wr_led   = wr && (idx == REG_LED);
   assign wr_tcnt  = wr && (idx == REG_TCNT);
   assign wr_tcmp  = wr && (idx == REG_TCMP);
   assign wr_tctrl = wr && (idx == REG_TCTRL);
   assign wr_uart  = wr && (idx == REG_UART);

   logic [LED_W-1:0] led_q, sw_meta, sw_sync;
   logic [31:0]      tcnt, tcmp;
   tctrl_t           ctrl;
   logic             flag, irq_q, match, uart_busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q   <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
         if (wr_led)
            led_q <= ioWtData[LED_W-1:0];
      end
   end

   assign match = ctrl.en && (tcnt == tcmp);

   // Software write to TCNT overrides both reload and increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt <= '0;
         tcmp <= TCMP_RESET;
         ctrl <= '0;
      end else begin
         if (wr_tcnt)
            tcnt <= ioWtData;
         else if (match && ctrl.auto_reload)
            tcnt <= '0;
         else if (ctrl.en)
            tcnt <= tcnt + 32'd1;
         if (wr_tcmp)
            tcmp <= ioWtData;
         if (wr_tctrl)
            ctrl <= '{irq_en:      ioWtData[TCTRL_IE],
                      auto_reload: ioWtData[TCTRL_AR],
                      en:          ioWtData[TCTRL_EN]};
      end
   end

   // A match in the same cycle as a write-1-to-clear keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (match)
            flag <= 1'b1;
         else if (wr_tctrl && ioWtData[TCTRL_FLAG])
            flag <= 1'b0;
         irq_q <= flag & ctrl.irq_en;
      end
   end

   uart_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_uart_tx (
      .clk   (clk),
      .rst   (rst),
      .start (wr_uart),
      .data  (ioWtData[7:0]),
      .busy  (uart_busy),
      .tx    (uartTx)
   );

   always_comb begin
      ioRdData = ZERO;
      if (access) begin
         case (idx)
            REG_LED:   ioRdData = 32'(led_q);
            REG_SW:    ioRdData = 32'(sw_sync);
            REG_TCNT:  ioRdData = tcnt;
            REG_TCMP:  ioRdData = tcmp;
            REG_TCTRL: ioRdData = {23'd0, flag, 5'd0, ctrl.irq_en, ctrl.auto_reload, ctrl.en};
            REG_UART:  ioRdData = {31'd0, uart_busy};
            default:   ioRdData = ZERO;
         endcase
      end
   end

   assign led = led_q;
   assign irq = irq_q;

endmodule

// File: tb/tb_io_dev.sv
// Self-checking bench for io_dev: register access, synchronizer, timer and
// a per-cycle UART line scoreboard fed when frames are written.
module tb_io_dev;

   localparam int CLK_DIV = 4;
   localparam int LED_W   = 16;

   localparam logic [31:0] A_LED   = 32'h7000_0000;
   localparam logic [31:0] A_SW    = 32'h7000_0004;
   localparam logic [31:0] A_TCNT  = 32'h7000_0008;
   localparam logic [31:0] A_TCMP  = 32'h7000_000C;
   localparam logic [31:0] A_TCTRL = 32'h7000_0010;
   localparam logic [31:0] A_UART  = 32'h7000_0014;
   localparam logic [31:0] A_NONE  = 32'h7000_0040;

   logic             clk, rst;
   logic             io_ce, io_we;
   logic [31:0]      io_addr, io_wt_data, io_rd_data;
   logic [LED_W-1:0] sw, led;
   logic             uart_tx, irq;

   int n_checks = 0;
   int n_errors = 0;
   bit tx_q[$];
   bit exp_tx;
   logic [31:0] rd_val;

   io_dev #(
      .CLK_DIV (CLK_DIV),
      .LED_W   (LED_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ioCe     (io_ce),
      .ioWe     (io_we),
      .ioAddr   (io_addr),
      .ioWtData (io_wt_data),
      .ioRdData (io_rd_data),
      .sw       (sw),
      .led      (led),
      .uartTx   (uart_tx),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      io_ce      = 1'b1;
      io_we      = 1'b1;
      io_addr    = a;
      io_wt_data = d;
      @(posedge clk);
      #1;
      io_ce = 1'b0;
      io_we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      io_ce   = 1'b1;
      io_we   = 1'b0;
      io_addr = a;
      #1;
      d     = io_rd_data;
      io_ce = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++)
         repeat (CLK_DIV) tx_q.push_back(f[i]);
   endtask

   // Idle line is expected whenever no frame is queued.
   always @(negedge clk) begin
      exp_tx = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b1;
      chk("uart_line", 32'(uart_tx), 32'(exp_tx));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b0;
      io_ce      = 1'b0;
      io_we      = 1'b0;
      io_addr    = '0;
      io_wt_data = '0;
      sw         = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();

      rd(A_TCMP, rd_val);  chk("rst_tcmp", rd_val, 32'hFFFF_FFFF);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_led", 32'(led), 32'd0);

      wr(A_LED, 32'h1234_ABCD);
      chk("led_pin", 32'(led), 32'h0000_ABCD);
      rd(A_LED, rd_val);   chk("led_read", rd_val, 32'h0000_ABCD);
      rd(A_NONE, rd_val);  chk("unmapped_read", rd_val, 32'd0);
      io_ce = 1'b0; io_we = 1'b0; io_addr = A_LED; #1;
      chk("ce_off_read", io_rd_data, 32'd0);

      wr(A_SW, 32'h0000_FFFF);
      rd(A_SW, rd_val);    chk("sw_ro", rd_val, 32'd0);
      sw = 16'h00F0;
      rd(A_SW, rd_val);    chk("sw_sync0", rd_val, 32'd0);
      tick();
      rd(A_SW, rd_val);    chk("sw_sync1", rd_val, 32'd0);
      tick();
      rd(A_SW, rd_val);    chk("sw_sync2", rd_val, 32'h0000_00F0);

      // Timer: compare 5, enable with reload and irq.
      wr(A_TCMP, 32'd5);
      wr(A_TCTRL, 32'h7);
      rd(A_TCNT, rd_val);  chk("tcnt_start", rd_val, 32'd0);
      repeat (5) tick();
      rd(A_TCTRL, rd_val); chk("flag_before", rd_val, 32'h007);
      rd(A_TCNT, rd_val);  chk("tcnt_at_cmp", rd_val, 32'd5);
      tick();
      rd(A_TCTRL, rd_val); chk("flag_set", rd_val, 32'h107);
      rd(A_TCNT, rd_val);  chk("tcnt_reload", rd_val, 32'd0);
      chk("irq_lag", 32'(irq), 32'd0);
      tick();
      chk("irq_set", 32'(irq), 32'd1);
      rd(A_TCNT, rd_val);  chk("tcnt_after", rd_val, 32'd1);
      wr(A_TCTRL, 32'h107);
      rd(A_TCTRL, rd_val); chk("flag_clear", rd_val, 32'h007);
      tick();
      chk("irq_clear", 32'(irq), 32'd0);
      tick();
      tick();
      rd(A_TCNT, rd_val);  chk("tcnt_pre_match", rd_val, 32'd5);
      wr(A_TCTRL, 32'h107);
      rd(A_TCTRL, rd_val); chk("set_beats_clear", rd_val, 32'h107);
      rd(A_TCNT, rd_val);  chk("tcnt_reload2", rd_val, 32'd0);
      tick();
      chk("irq_set2", 32'(irq), 32'd1);
      wr(A_TCTRL, 32'h100);
      rd(A_TCTRL, rd_val); chk("flag_clear2", rd_val, 32'h000);
      tick();
      chk("irq_clear2", 32'(irq), 32'd0);
      wr(A_TCTRL, 32'h1);
      wr(A_TCNT, 32'hFFFF_FFFF);
      rd(A_TCNT, rd_val);  chk("tcnt_write", rd_val, 32'hFFFF_FFFF);
      tick();
      rd(A_TCNT, rd_val);  chk("tcnt_wrap", rd_val, 32'd0);
      wr(A_TCTRL, 32'h0);

      // UART: one frame, a dropped write, then a back-to-back frame.
      wr(A_UART, 32'h0000_00A5);
      push_frame(8'hA5);
      rd(A_UART, rd_val);  chk("busy_start", rd_val, 32'd1);
      repeat (9) tick();
      wr(A_UART, 32'h0000_003C);
      repeat (29) tick();
      rd(A_UART, rd_val);  chk("busy_last", rd_val, 32'd1);
      tick();
      rd(A_UART, rd_val);  chk("busy_done", rd_val, 32'd0);
      wr(A_UART, 32'h0000_005A);
      push_frame(8'h5A);
      repeat (20) tick();

      // Asynchronous reset in the middle of the second frame.
      rst = 1'b0;
      tx_q.delete();
      #1;
      chk("rst_tx", 32'(uart_tx), 32'd1);
      chk("rst_led2", 32'(led), 32'd0);
      chk("rst_irq2", 32'(irq), 32'd0);
      rd(A_TCMP, rd_val);  chk("rst_tcmp2", rd_val, 32'hFFFF_FFFF);
      rd(A_SW, rd_val);    chk("rst_sw", rd_val, 32'd0);
      rd(A_UART, rd_val);  chk("rst_busy", rd_val, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (8) tick();
      rd(A_UART, rd_val);  chk("post_rst_idle", rd_val, 32'd0);
      chk("post_rst_tx", 32'(uart_tx), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/io_dev.md
# io_dev

Memory-mapped IO responder at the device end of the IO port driven by the CPU's memory/IO controller. It decodes IO accesses in the 0x7000_0000 region and serves these functions:
- LED output register.
- Synchronized switch input.
- 32-bit timer with compare match and interrupt.
- 8N1 UART transmitter.

Writes are sampled on the clock edge. Read data is returned combinationally in the same cycle, so the controller's read mux closes within one CPU memory stage.

## Interface
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- LED_W, 16, width of LED register and switch input.
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- ioCe  input  1  access strobe; compared against `RamEnable.
- ioWe  input  1  write qualifier; compared against `RamWrite.
- ioAddr  input  32  byte address; ioAddr[7:2] selects the register, ioAddr[1:0] is ignored.
- ioWtData  input  32  write data.
- ioRdData  output  32  read data, combinational.
- sw  input  LED_W  asynchronous switch pins.
- led  output  LED_W  LED register.
- uartTx  output  1  serial line; idles high.
- irq  output  1  timer interrupt, registered.

## Operation
Register map (offset from 0x7000_0000):
- 0x00 LED: RW, LED_W bits; upper bits read 0.
- 0x04 SW: RO; returns the 2-flop synchronized sw.
- 0x08 TCNT: RW counter.
- 0x0C TCMP: RW compare value.
- 0x10 TCTRL: bit0 en, bit1 autoReload, bit2 irqEn (all RW); bit8 match flag (write 1 to clear).
- 0x14 UART: write loads ioWtData[7:0]; read returns bit0 = busy.

Write and read rules:
- A write occurs when ioCe==`RamEnable and ioWe==`RamWrite at posedge clk.
- Writes to RO or unmapped offsets are ignored.
- ioRdData = `Zero when ioCe != `RamEnable, or when the offset is unmapped.
- Reads have no side effects; the flag is not cleared by reading.

Timer:
- When en=1, TCNT increments by 1 each cycle and wraps modulo 2^32.
- When TCNT == TCMP and en=1, flag is set on the next edge.
- If autoReload=1, TCNT loads 0 on that same edge instead of incrementing.
- A software write to TCNT takes priority over both increment and reload.
- When a match set and a W1C clear of the flag happen in the same cycle, the set wins.
- irq <= flag & irqEn, registered (one cycle after flag).

UART transmitter FSM with states IDLE, START, DATA, STOP:
- IDLE: uartTx=1, busy=0. A UART write latches the byte, clears the bit counter, moves to START and sets busy.
- START: drives 0 for CLK_DIV cycles.
- DATA: drives shift[0] for CLK_DIV cycles per bit, 8 bits, LSB first.
- STOP: drives 1 for CLK_DIV cycles, then returns to IDLE.
- busy is 1 in every state except IDLE.
- A UART write while busy is dropped; there is no queue.
- Baud counter counts 0..CLK_DIV-1. The bit advances when the counter reaches CLK_DIV-1.

Reset (rst=0, asynchronous, at any time, including mid-frame):
- led=0, TCNT=0, TCMP=0xFFFF_FFFF, TCTRL=0, flag=0, irq=0.
- Synchronizer flops = 0.
- FSM = IDLE, uartTx=1; an in-progress frame is abandoned.

## Timing
- Write latency: a register is updated at the edge that samples the write. A read in the next cycle returns the new value.
- Read latency: 0 cycles, combinational from ioAddr/ioCe.
- sw to SW readback: 2 clk cycles.
- Timer match to flag: 1 cycle. Match to irq: 2 cycles.
- UART write to first start-bit edge on uartTx: 1 cycle.
- Frame length: 10*CLK_DIV cycles. busy falls at the end of the stop bit.
- Back-to-back frames: a write accepted in the first IDLE cycle after STOP yields a continuous stream with no extra idle bit.

## Structure
- Register offsets, TCTRL bit positions and UART state encodings are added to define.v next to `RamEnable, `RamWrite and `Zero.
- One sub-module, uart_tx, holds the FSM, baud counter and shift register. Its ports are clk, rst, start, data[7:0], busy, tx.
- Register file, timer, synchronizer and read mux stay in io_dev.

## Test plan
Benches use CLK_DIV=4.
- Reset: assert rst=0 mid-frame -> uartTx=1, led=0, irq=0, TCMP reads 0xFFFF_FFFF, SW/UART read 0.
- LED/decode: write 0x1234_ABCD to 0x7000_0000 -> led=0xABCD, read returns 0x0000_ABCD. Read 0x7000_0040 -> 0. Read with ioCe disabled -> 0.
- Synchronizer: sw=0x00F0 -> SW read returns 0x00F0 after exactly 2 cycles, 0 before.
- Timer:
  - Write TCMP=5, then TCTRL=0x7 -> flag set 6 cycles after enable, irq one cycle later, TCNT reloads to 0.
  - Write 0x100 to TCTRL in the match cycle -> flag stays 1.
  - Write 0x100 in a later cycle -> flag=0 and irq=0 the following cycle.
- UART:
  - Write 0xA5 -> uartTx sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles each. busy=1 for 40 cycles.
  - Write 0x3C while busy -> ignored; the frame is unchanged.
- Back-to-back UART: a second write in the first idle cycle after the frame -> the next start bit follows the stop bit immediately.
